fwnoc_router_wh: RTL

//  5-port wormhole mesh router with parametrised flit width, buffering and coordinates.

---
 rtl/fwnoc_router_wh.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fwnoc_router_wh.sv
// 5-port wormhole mesh router: per-port ingress FIFOs, XY routing on the header at a FIFO
// head, and per-egress round-robin arbitration that locks an egress to one source until
// the last flit of the packet has left. Port order: 0=H 1=N 2=S 3=E 4=W.
module fwnoc_router_wh #(
    parameter int DAT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int COORD_W    = 4,
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             i_valid,
    output logic [4:0]             i_ready,
    input  logic [5*DAT_WIDTH-1:0] i_dat,
    output logic [4:0]             e_valid,
    input  logic [4:0]             e_ready,
    output logic [5*DAT_WIDTH-1:0] e_dat
);
    localparam int NP = 5;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [COORD_W-1:0] X_C    = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] Y_C    = COORD_W'(Y_ID);
    localparam logic [CW-1:0]      FULL_C = CW'(FIFO_DEPTH);

    typedef enum logic {EG_IDLE, EG_BUSY} eg_state_e;

    logic [DAT_WIDTH-1:0] mem_q    [NP][FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr_q [NP];
    logic [AW-1:0]        rd_ptr_d [NP];
    logic [AW-1:0]        wr_ptr_q [NP];
    logic [AW-1:0]        wr_ptr_d [NP];
    logic [CW-1:0]        cnt_q    [NP];
    logic [CW-1:0]        cnt_d    [NP];
    logic [7:0]           rem_q    [NP];
    logic [7:0]           rem_d    [NP];
    eg_state_e            state_q  [NP];
    eg_state_e            state_d  [NP];
    logic [2:0]           src_q    [NP];
    logic [2:0]           src_d    [NP];
    logic [2:0]           ptr_q    [NP];
    logic [2:0]           ptr_d    [NP];

    logic [NP-1:0]        push, pop, full, nempty, is_hdr, last, locked;
    logic [DAT_WIDTH-1:0] head  [NP];
    logic [2:0]           route [NP];
    logic [NP-1:0]        req   [NP];
    logic [3:0]           cand;
    logic                 gnt_found;

    // Ingress view: head flit, header/last classification, XY route and egress request
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            head[p]    = mem_q[p][rd_ptr_q[p]];
            full[p]    = (cnt_q[p] == FULL_C);
            nempty[p]  = (cnt_q[p] != '0);
            is_hdr[p]  = (rem_q[p] == 8'd0);
            last[p]    = is_hdr[p] ? (head[p][2*COORD_W +: 8] == 8'd0) : (rem_q[p] == 8'd1);
            i_ready[p] = !full[p] && !reset;
            push[p]    = i_valid[p] && i_ready[p];
            if (head[p][COORD_W-1:0] > X_C)
                route[p] = 3'd3;
            else if (head[p][COORD_W-1:0] < X_C)
                route[p] = 3'd4;
            else if (head[p][2*COORD_W-1:COORD_W] > Y_C)
                route[p] = 3'd2;
            else if (head[p][2*COORD_W-1:COORD_W] < Y_C)
                route[p] = 3'd1;
            else
                route[p] = 3'd0;
            locked[p] = 1'b0;
            for (int e = 0; e < NP; e++) begin
                if (state_q[e] == EG_BUSY && src_q[e] == 3'(p))
                    locked[p] = 1'b1;
            end
            req[p] = '0;
            if (nempty[p] && is_hdr[p] && !locked[p])
                req[p][route[p]] = 1'b1;
        end
    end

    // Egress FSMs: round-robin grant in IDLE, stream the locked source in BUSY
    always_comb begin
        pop       = '0;
        e_valid   = '0;
        e_dat     = '0;
        cand      = '0;
        gnt_found = 1'b0;
        for (int e = 0; e < NP; e++) begin
            state_d[e] = state_q[e];
            src_d[e]   = src_q[e];
            ptr_d[e]   = ptr_q[e];
            gnt_found  = 1'b0;
            if (state_q[e] == EG_BUSY) begin
                if (nempty[src_q[e]]) begin
                    e_valid[e] = 1'b1;
                    e_dat[e*DAT_WIDTH +: DAT_WIDTH] = head[src_q[e]];
                    if (e_ready[e]) begin
                        pop[src_q[e]] = 1'b1;
                        if (last[src_q[e]])
                            state_d[e] = EG_IDLE;
                    end
                end
            end else begin
                for (int off = 0; off < NP; off++) begin
                    cand = {1'b0, ptr_q[e]} + 4'(off);
                    if (cand >= 4'd5)
                        cand = cand - 4'd5;
                    if (!gnt_found && req[cand[2:0]][e]) begin
                        gnt_found  = 1'b1;
                        state_d[e] = EG_BUSY;
                        src_d[e]   = cand[2:0];
                        ptr_d[e]   = (cand == 4'd4) ? 3'd0 : cand[2:0] + 3'd1;
                    end
                end
            end
        end
    end

    // FIFO pointers, occupancy and the remaining-flit counter that tracks header vs payload
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            wr_ptr_d[p] = push[p] ? wr_ptr_q[p] + AW'(1) : wr_ptr_q[p];
            rd_ptr_d[p] = pop[p]  ? rd_ptr_q[p] + AW'(1) : rd_ptr_q[p];
            cnt_d[p]    = cnt_q[p];
            if (push[p] && !pop[p])
                cnt_d[p] = cnt_q[p] + CW'(1);
            else if (!push[p] && pop[p])
                cnt_d[p] = cnt_q[p] - CW'(1);
            rem_d[p] = rem_q[p];
            if (pop[p])
                rem_d[p] = is_hdr[p] ? head[p][2*COORD_W +: 8] : rem_q[p] - 8'd1;
        end
    end

    // Control state, cleared asynchronously so a reset abandons any packet in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                rd_ptr_q[p] <= '0;
                wr_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
                rem_q[p]    <= '0;
                state_q[p]  <= EG_IDLE;
                src_q[p]    <= '0;
                ptr_q[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                rd_ptr_q[p] <= rd_ptr_d[p];
                wr_ptr_q[p] <= wr_ptr_d[p];
                cnt_q[p]    <= cnt_d[p];
                rem_q[p]    <= rem_d[p];
                state_q[p]  <= state_d[p];
                src_q[p]    <= src_d[p];
                ptr_q[p]    <= ptr_d[p];
            end
        end
    end

    // Flit storage; stale contents are harmless because occupancy gates every read
    always_ff @(posedge clock) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p])
                mem_q[p][wr_ptr_q[p]] <= i_dat[p*DAT_WIDTH +: DAT_WIDTH];
        end
    end

endmodule
